// File: rtl/legv8_control_fsm_if.sv
// Control-word bus between the multicycle control unit and the LEGv8 datapath.
interface legv8_control_fsm_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    // Datapath to controller
    logic [XLEN-1:0] IR_out;
    logic [3:0]      status;

    // Controller to datapath
    logic            w_reg;
    logic            C0;
    logic            mem_cs;
    logic            mem_write_en;
    logic            IR_load;
    logic            status_load;
    logic            B_Sel;
    logic [XLEN-1:0] k;
    logic [4:0]      FS;
    logic [1:0]      size;
    logic [RW-1:0]   SA;
    logic [RW-1:0]   SB;
    logic [RW-1:0]   DA;
    logic [1:0]      PC_sel;
    logic            add_tri_sel;
    logic [1:0]      data_tri_sel;
    logic            halted;
    logic            instr_done;

    modport master (
        input  IR_out, status,
        output w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel,
               k, FS, size, SA, SB, DA, PC_sel, add_tri_sel, data_tri_sel,
               halted, instr_done
    );

    modport slave (
        output IR_out, status,
        input  w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel,
               k, FS, size, SA, SB, DA, PC_sel, add_tri_sel, data_tri_sel,
               halted, instr_done
    );
endinterface

// File: rtl/legv8_control_fsm.sv
// Multicycle LEGv8-subset control unit: fetch, execute, memory and branch
// sequencing. The control word is decoded from the state and IR_out.
module legv8_control_fsm (
    input  logic                 clock,
    input  logic                 reset,
    legv8_control_fsm_if.master  bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_PASSA = 5'b00100;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;

    typedef enum logic [2:0] {
        FETCH1 = 3'd0,
        FETCH2 = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } state_e;

    state_e            state_q;
    state_e            state_d;

    logic [XLEN-1:0]   ir;
    logic              is_alu;
    logic              is_imm;
    logic [4:0]        alu_fs;
    logic              alu_c0;
    logic              is_ldur;
    logic              is_stur;
    logic              is_b;
    logic              is_cb;
    logic [XLEN-1:0]   k_mem;
    logic [XLEN-1:0]   k_b;
    logic [XLEN-1:0]   k_cb;
    logic              cb_taken;
    logic              unused_status;

    assign ir            = bus.IR_out;
    assign unused_status = ^bus.status[3:1];

    // Instruction class, ALU function and sign-extended offsets
    always_comb begin
        is_alu  = 1'b1;
        is_imm  = 1'b0;
        alu_fs  = FS_ADD;
        alu_c0  = 1'b0;
        if (ir[31:21] == OP_ADD) begin
            alu_fs = FS_ADD;
        end else if (ir[31:21] == OP_SUB) begin
            alu_fs = FS_SUB;
            alu_c0 = 1'b1;
        end else if (ir[31:21] == OP_AND) begin
            alu_fs = FS_AND;
        end else if (ir[31:21] == OP_ORR) begin
            alu_fs = FS_ORR;
        end else if (ir[31:22] == OP_ADDI) begin
            is_imm = 1'b1;
            alu_fs = FS_ADD;
        end else if (ir[31:22] == OP_SUBI) begin
            is_imm = 1'b1;
            alu_fs = FS_SUB;
            alu_c0 = 1'b1;
        end else begin
            is_alu = 1'b0;
        end
        is_ldur  = (ir[31:21] == OP_LDUR);
        is_stur  = (ir[31:21] == OP_STUR);
        is_b     = (ir[31:26] == OP_B);
        is_cb    = (ir[31:24] == OP_CBZ) || (ir[31:24] == OP_CBNZ);
        k_mem    = {{23{ir[20]}}, ir[20:12]};
        k_b      = {{4{ir[25]}}, ir[25:0], 2'b00};
        k_cb     = {{11{ir[23]}}, ir[23:5], 2'b00};
        // IR[24] distinguishes CBNZ (1) from CBZ (0); Z is status[0]
        cb_taken = ir[24] ^ bus.status[0];
    end

    // State register; low reset returns to FETCH1 from any state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control word; idle word while reset is low
    always_comb begin
        state_d          = state_q;
        bus.w_reg        = 1'b0;
        bus.C0           = 1'b0;
        bus.mem_cs       = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.IR_load      = 1'b0;
        bus.status_load  = 1'b0;
        bus.B_Sel        = 1'b0;
        bus.k            = '0;
        bus.FS           = 5'b00000;
        bus.size         = 2'b10;
        bus.SA           = 5'd0;
        bus.SB           = 5'd0;
        bus.DA           = 5'd31;
        bus.PC_sel       = 2'b00;
        bus.add_tri_sel  = 1'b1;
        bus.data_tri_sel = 2'd0;
        bus.halted       = 1'b0;
        bus.instr_done   = 1'b0;

        if (reset) begin
            case (state_q)
                FETCH1: begin
                    bus.mem_cs       = 1'b1;
                    bus.data_tri_sel = 2'd3;
                    state_d          = FETCH2;
                end
                FETCH2: begin
                    bus.mem_cs       = 1'b1;
                    bus.data_tri_sel = 2'd3;
                    bus.IR_load      = 1'b1;
                    state_d          = EXEC;
                end
                EXEC: begin
                    if (is_alu) begin
                        bus.SA         = ir[9:5];
                        bus.SB         = ir[20:16];
                        bus.DA         = ir[4:0];
                        bus.B_Sel      = is_imm;
                        bus.k          = is_imm ? XLEN'(ir[21:10]) : '0;
                        bus.FS         = alu_fs;
                        bus.C0         = alu_c0;
                        bus.w_reg      = 1'b1;
                        bus.PC_sel     = 2'b01;
                        bus.instr_done = 1'b1;
                        state_d        = FETCH1;
                    end else if (is_ldur || is_stur) begin
                        bus.SA          = ir[9:5];
                        bus.B_Sel       = 1'b1;
                        bus.k           = k_mem;
                        bus.FS          = FS_ADD;
                        bus.add_tri_sel = 1'b0;
                        bus.mem_cs      = 1'b1;
                        bus.size        = 2'b11;
                        if (is_ldur) begin
                            bus.data_tri_sel = 2'd3;
                            state_d          = MEM;
                        end else begin
                            bus.SB           = ir[4:0];
                            bus.data_tri_sel = 2'd1;
                            bus.mem_write_en = 1'b1;
                            bus.PC_sel       = 2'b01;
                            bus.instr_done   = 1'b1;
                            state_d          = FETCH1;
                        end
                    end else if (is_b) begin
                        bus.PC_sel     = 2'b10;
                        bus.k          = k_b;
                        bus.instr_done = 1'b1;
                        state_d        = FETCH1;
                    end else if (is_cb) begin
                        // Pass the tested register through the ALU to latch Z
                        bus.SA          = ir[4:0];
                        bus.B_Sel       = 1'b1;
                        bus.FS          = FS_PASSA;
                        bus.status_load = 1'b1;
                        state_d         = BRANCH;
                    end else begin
                        state_d = HALT;
                    end
                end
                MEM: begin
                    bus.SA           = ir[9:5];
                    bus.B_Sel        = 1'b1;
                    bus.k            = k_mem;
                    bus.FS           = FS_ADD;
                    bus.add_tri_sel  = 1'b0;
                    bus.mem_cs       = 1'b1;
                    bus.data_tri_sel = 2'd3;
                    bus.size         = 2'b11;
                    bus.DA           = ir[4:0];
                    bus.w_reg        = 1'b1;
                    bus.PC_sel       = 2'b01;
                    bus.instr_done   = 1'b1;
                    state_d          = FETCH1;
                end
                BRANCH: begin
                    if (cb_taken) begin
                        bus.PC_sel = 2'b10;
                        bus.k      = k_cb;
                    end else begin
                        bus.PC_sel = 2'b01;
                    end
                    bus.instr_done = 1'b1;
                    state_d        = FETCH1;
                end
                HALT: begin
                    bus.halted = 1'b1;
                    state_d    = HALT;
                end
                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end
endmodule
